// File: rtl/mux_arbiter_if.sv
// Requester/arbiter bundle for mux_arbiter: request and word lanes in, one-hot
// grant, owner index, busy, muxed word and timeout pulse out.
interface mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic [SW-1:0]  sel;
  logic           busy;
  logic [W-1:0]   data_out;
  logic           timeout;

  modport master (
    output req, data_in,
    input  grant, sel, busy, data_out, timeout
  );

  modport slave (
    input  req, data_in,
    output grant, sel, busy, data_out, timeout
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin owner of a shared N:1 word mux. Build macro MUX_ARB_TIMEOUT_EN adds
// a hold counter that forces release after MAX_HOLD grant cycles.
//
//   state | meaning
//   IDLE  | no owner; arbitrate from ptr on the next edge
//   GRANT | sel owns the mux until it drops req (or the hold limit expires)
module mux_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst_n,
  mux_arbiter_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          timeout_q, timeout_d;
  logic [SW-1:0] pick, cand, ptr_next;
  logic          found;
  logic [W-1:0]  words [N];

  for (genvar g = 0; g < N; g++) begin : g_words
    assign words[g] = bus.data_in[g*W +: W];
  end

  // First requester at or after ptr, wrapping past N-1 back to 0.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = SW'((int'(ptr_q) + i) % N);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign ptr_next = (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = GRANT;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          sel_d         = pick;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d         = CW'(MAX_HOLD - 1);
`endif
        end
      end
      GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
          ptr_d   = ptr_next;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        // Down-counter reaching zero marks the MAX_HOLD-th grant cycle.
        else if (cnt_q == '0) begin
          state_d   = IDLE;
          grant_d   = '0;
          sel_d     = '0;
          ptr_d     = ptr_next;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q == GRANT);
  assign bus.data_out = (state_q == GRANT) ? words[sel_q] : '0;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (N=4, W=8, MAX_HOLD=4); covers the timeout
// path when built with MUX_ARB_TIMEOUT_EN, the indefinite hold otherwise.
module tb_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  mux_arbiter_if #(.N(N), .W(W)) bus ();

  mux_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic [7:0] d);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(d));
  endtask

  initial begin
    logic [3:0] onehot;
    bus.req     = 4'b0000;
    bus.data_in = {8'hC4, 8'h33, 8'hA5, 8'h11};

    // reset values while held
    tick();
    tick();
    chk_state("reset", 4'b0000, 2'd0, 1'b0, 8'h00);
    chk("reset.timeout", 32'(bus.timeout), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_state("idle_no_req", 4'b0000, 2'd0, 1'b0, 8'h00);

    // simultaneous requests from ptr=0: lowest at/after 0 -> 1
    bus.req = 4'b1010;
    tick();
    chk_state("simul_grant1", 4'b0010, 2'd1, 1'b1, 8'hA5);
    bus.data_in[15:8] = 8'h5A;
    #1;
    chk("live_data_out", 32'(bus.data_out), 32'h5A);
    bus.req = 4'b1000;
    tick();
    chk_state("dead_cycle", 4'b0000, 2'd0, 1'b0, 8'h00);
    tick();
    chk_state("simul_grant3", 4'b1000, 2'd3, 1'b1, 8'hC4);

    // lone req[3] pulsed: ptr wraps to 0, re-wins after one dead cycle
    for (int k = 0; k < 2; k++) begin
      bus.req = 4'b0000;
      tick();
      chk_state("wrap_idle", 4'b0000, 2'd0, 1'b0, 8'h00);
      bus.req = 4'b1000;
      tick();
      chk_state("wrap_regrant", 4'b1000, 2'd3, 1'b1, 8'hC4);
    end
    bus.req = 4'b0000;
    tick();
    chk_state("wrap_release", 4'b0000, 2'd0, 1'b0, 8'h00);

    // fairness: all request, each owner holds 2 cycles then drops for one
    bus.data_in = {8'hC4, 8'h33, 8'hA5, 8'h11};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      onehot = 4'b0001 << (k % 4);
      tick();
      chk_state("fair_grant", onehot, 2'(k % 4), 1'b1, bus.data_in[(k%4)*8 +: 8]);
      tick();
      chk("fair_hold", 32'(bus.grant), 32'(onehot));
      bus.req = 4'b1111 & ~onehot;
      tick();
      chk_state("fair_dead", 4'b0000, 2'd0, 1'b0, 8'h00);
      bus.req = 4'b1111;
    end

    // owner 0 (from last fairness round) released; ptr=1 -> owner 2
    bus.req = 4'b0100;
    tick();
    chk_state("nopre_grant2", 4'b0100, 2'd2, 1'b1, 8'h33);
    bus.req = 4'b0101;
    tick();
    chk("nopre_hold_a", 32'(bus.grant), 32'h4);
    tick();
    chk("nopre_hold_b", 32'(bus.grant), 32'h4);
    bus.req = 4'b0001;
    tick();
    chk_state("nopre_dead", 4'b0000, 2'd0, 1'b0, 8'h00);
    tick();
    chk_state("nopre_grant0", 4'b0001, 2'd0, 1'b1, 8'h11);

    // one-cycle grant: req dropped in the granted cycle (ptr=1 after release)
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0010;
    tick();
    chk("oneshot_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    tick();
    chk_state("oneshot_release", 4'b0000, 2'd0, 1'b0, 8'h00);

    // async reset mid-grant (ptr=2 now)
    bus.req = 4'b0100;
    tick();
    chk("prereset_grant", 32'(bus.grant), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_reset", 4'b0000, 2'd0, 1'b0, 8'h00);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk_state("post_reset_grant", 4'b0100, 2'd2, 1'b1, 8'h33);
    bus.req = 4'b0000;
    tick();
    chk_state("post_reset_release", 4'b0000, 2'd0, 1'b0, 8'h00);

    // ptr=3: req 0011 scans 3,0 -> owner 0
    bus.req = 4'b0011;
    tick();
    chk_state("hold_grant0", 4'b0001, 2'd0, 1'b1, 8'h11);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_hold_grant", 32'(bus.grant), 32'h1);
      chk("to_hold_timeout", 32'(bus.timeout), 32'd0);
    end
    tick();
    chk_state("to_release", 4'b0000, 2'd0, 1'b0, 8'h00);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    tick();
    chk_state("to_next_owner", 4'b0010, 2'd1, 1'b1, 8'hA5);
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);
`else
    for (int k = 0; k < 120; k++) begin
      tick();
      chk("nohold_grant", 32'(bus.grant), 32'h1);
      chk("nohold_timeout", 32'(bus.timeout), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
